// File: rtl/crc_frame_ctrl.sv
// Byte-serial CRC engine with frame framing: one byte per clock, registered result
// held until the consumer handshakes it, abort and synchronous reset discard a frame.
module crc_frame_ctrl #(
    parameter int              BITS   = 8,
    parameter logic [BITS-1:0] POLY   = 8'h07,
    parameter logic [BITS-1:0] INIT   = '0,
    parameter logic [BITS-1:0] XOROUT = '0,
    parameter bit              REFIN  = 1'b0,
    parameter bit              REFOUT = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [7:0]      s_data,
    input  logic            s_last,
    input  logic            abort,
    output logic            crc_valid,
    input  logic            crc_ready,
    output logic [BITS-1:0] crc_out,
    output logic [15:0]     byte_cnt,
    output logic            busy
);

    // state | meaning
    // IDLE  | no frame open, crc register holds INIT
    // RUN   | frame open, accumulating bytes
    // DONE  | result presented, waiting for crc_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] crc_q, crc_d;
    logic [BITS-1:0] out_q, out_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            accept;
    logic [BITS-1:0] crc_next;

    function automatic logic [7:0] reflect8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

    function automatic logic [BITS-1:0] reflect_w(input logic [BITS-1:0] d);
        logic [BITS-1:0] r;
        for (int i = 0; i < BITS; i++) begin
            r[i] = d[BITS-1-i];
        end
        return r;
    endfunction

    // MSB-first bitwise update over one byte, unrolled into a single cycle.
    function automatic logic [BITS-1:0] crc_step(input logic [BITS-1:0] crc,
                                                 input logic [7:0]      din);
        logic [BITS-1:0] c;
        logic [BITS-1:0] ext;
        ext = BITS'(din) << (BITS - 8);
        c   = crc ^ ext;
        for (int i = 0; i < 8; i++) begin
            if (c[BITS-1]) begin
                c = (c << 1) ^ POLY;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

    function automatic logic [BITS-1:0] finalize(input logic [BITS-1:0] crc);
        logic [BITS-1:0] r;
        r = REFOUT ? reflect_w(crc) : crc;
        return r ^ XOROUT;
    endfunction

    assign s_ready   = (state_q != DONE);
    assign crc_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign crc_out   = out_q;
    assign byte_cnt  = cnt_q;

    assign accept   = s_valid && s_ready;
    assign crc_next = crc_step(crc_q, REFIN ? reflect8(s_data) : s_data);

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    crc_d = crc_next;
                    if (state_q == IDLE) begin
                        cnt_d = 16'd1;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (s_last) begin
                        out_d   = finalize(crc_next);
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                if (crc_ready) begin
                    state_d = IDLE;
                    crc_d   = INIT;
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = INIT;
            end
        endcase

        // Abort wins over any coincident byte; the last published result is kept.
        if (abort) begin
            state_d = IDLE;
            crc_d   = INIT;
            cnt_d   = 16'd0;
            out_d   = out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            out_q   <= '0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed bench: three CRC flavours driven by one shared byte stream, with
// hand-computed check values for "123456789" and the framing corner cases.
module tb_crc_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_last, abort, crc_ready;
    logic [7:0]  s_data;

    logic        s_ready8,  crc_valid8,  busy8;
    logic [7:0]  crc8;
    logic [15:0] cnt8;
    logic        s_ready16, crc_valid16, busy16;
    logic [15:0] crc16;
    logic [15:0] cnt16;
    logic        s_ready32, crc_valid32, busy32;
    logic [31:0] crc32;
    logic [15:0] cnt32;

    logic [7:0]  msg [0:8];
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    crc_frame_ctrl u8 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
        .s_last(s_last), .abort(abort), .crc_valid(crc_valid8), .crc_ready(crc_ready),
        .crc_out(crc8), .byte_cnt(cnt8), .busy(busy8)
    );

    crc_frame_ctrl #(.BITS(16), .POLY(16'h1021), .INIT(16'hFFFF)) u16 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready16), .s_data(s_data),
        .s_last(s_last), .abort(abort), .crc_valid(crc_valid16), .crc_ready(crc_ready),
        .crc_out(crc16), .byte_cnt(cnt16), .busy(busy16)
    );

    crc_frame_ctrl #(.BITS(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                     .XOROUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1)) u32 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready32), .s_data(s_data),
        .s_last(s_last), .abort(abort), .crc_valid(crc_valid32), .crc_ready(crc_ready),
        .crc_out(crc32), .byte_cnt(cnt32), .busy(busy32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams the 9 message bytes without bubbles; leaves the bench 1 cycle after the last edge.
    task automatic stream_frame();
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = (i == 8);
            vectors++;
            if (s_ready8 !== 1'b1 || crc_valid8 !== 1'b0) begin
                $display("FAIL stream_byte%0d: s_ready=%b crc_valid=%b, want 1/0", i, s_ready8, crc_valid8);
                errors++;
            end
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = 1'b0;
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic handshake();
        crc_ready = 1'b1;
        tick();
        crc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; abort = 1'b0; crc_ready = 1'b0; s_data = 8'h00;
        tick(); tick();
        vectors++;
        if (crc8 !== 8'h00 || crc_valid8 !== 1'b0 || cnt8 !== 16'd0 || busy8 !== 1'b0) begin
            $display("FAIL reset_state: crc=%h valid=%b cnt=%0d busy=%b, want 00/0/0/0", crc8, crc_valid8, cnt8, busy8);
            errors++;
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (s_ready8 !== 1'b1 || s_ready32 !== 1'b1) begin
            $display("FAIL reset_ready: s_ready8=%b s_ready32=%b, want 1", s_ready8, s_ready32);
            errors++;
        end
    endtask

    task automatic test_crc8();
        stream_frame();
        vectors++;
        if (crc_valid8 !== 1'b1 || crc8 !== 8'hF4 || cnt8 !== 16'd9 || busy8 !== 1'b0) begin
            $display("FAIL crc8: valid=%b crc=%h cnt=%0d busy=%b, want 1/f4/9/0", crc_valid8, crc8, cnt8, busy8);
            errors++;
        end
        handshake();
        vectors++;
        if (crc_valid8 !== 1'b0 || s_ready8 !== 1'b1) begin
            $display("FAIL crc8_release: valid=%b s_ready=%b, want 0/1", crc_valid8, s_ready8);
            errors++;
        end
    endtask

    task automatic test_crc16();
        stream_frame();
        vectors++;
        if (crc_valid16 !== 1'b1 || crc16 !== 16'h29B1 || cnt16 !== 16'd9) begin
            $display("FAIL crc16: valid=%b crc=%h cnt=%0d, want 1/29b1/9", crc_valid16, crc16, cnt16);
            errors++;
        end
        handshake();
    endtask

    task automatic test_crc32();
        stream_frame();
        vectors++;
        if (crc_valid32 !== 1'b1 || crc32 !== 32'hCBF43926 || cnt32 !== 16'd9) begin
            $display("FAIL crc32: valid=%b crc=%h cnt=%0d, want 1/cbf43926/9", crc_valid32, crc32, cnt32);
            errors++;
        end
        handshake();
    endtask

    task automatic test_stall();
        stream_frame();
        s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (s_ready8 !== 1'b0 || crc_valid8 !== 1'b1 || crc8 !== 8'hF4 || cnt8 !== 16'd9) begin
                $display("FAIL stall_cyc%0d: s_ready=%b valid=%b crc=%h cnt=%0d, want 0/1/f4/9",
                         i, s_ready8, crc_valid8, crc8, cnt8);
                errors++;
            end
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        handshake();
        vectors++;
        if (crc_valid8 !== 1'b0 || busy8 !== 1'b0 || cnt8 !== 16'd9) begin
            $display("FAIL stall_release: valid=%b busy=%b cnt=%0d, want 0/0/9", crc_valid8, busy8, cnt8);
            errors++;
        end
        stream_frame();
        vectors++;
        if (crc8 !== 8'hF4 || crc16 !== 16'h29B1) begin
            $display("FAIL stall_second: crc8=%h crc16=%h, want f4/29b1", crc8, crc16);
            errors++;
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        stream_frame();
        handshake();
        stream_frame();
        vectors++;
        if (crc_valid32 !== 1'b1 || crc32 !== 32'hCBF43926 || crc8 !== 8'hF4) begin
            $display("FAIL back_to_back: valid=%b crc32=%h crc8=%h, want 1/cbf43926/f4", crc_valid32, crc32, crc8);
            errors++;
        end
        handshake();
    endtask

    task automatic test_abort();
        send_bytes(3);
        vectors++;
        if (busy8 !== 1'b1 || cnt8 !== 16'd3) begin
            $display("FAIL abort_pre: busy=%b cnt=%0d, want 1/3", busy8, cnt8);
            errors++;
        end
        s_valid = 1'b1; s_data = msg[3]; abort = 1'b1;
        tick();
        s_valid = 1'b0; abort = 1'b0;
        vectors++;
        if (busy8 !== 1'b0 || cnt8 !== 16'd0 || crc_valid8 !== 1'b0 || crc8 !== 8'hF4) begin
            $display("FAIL abort_post: busy=%b cnt=%0d valid=%b crc=%h, want 0/0/0/f4", busy8, cnt8, crc_valid8, crc8);
            errors++;
        end
        tick(); tick();
        vectors++;
        if (crc_valid8 !== 1'b0) begin
            $display("FAIL abort_novalid: valid=%b, want 0", crc_valid8);
            errors++;
        end
        stream_frame();
        vectors++;
        if (crc8 !== 8'hF4 || cnt8 !== 16'd9 || crc16 !== 16'h29B1) begin
            $display("FAIL abort_next: crc8=%h cnt=%0d crc16=%h, want f4/9/29b1", crc8, cnt8, crc16);
            errors++;
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        send_bytes(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (crc8 !== 8'h00 || crc32 !== 32'h0 || crc_valid8 !== 1'b0 || cnt8 !== 16'd0 ||
            busy8 !== 1'b0 || s_ready8 !== 1'b1) begin
            $display("FAIL reset_mid: crc8=%h crc32=%h valid=%b cnt=%0d busy=%b rdy=%b, want 00/0/0/0/0/1",
                     crc8, crc32, crc_valid8, cnt8, busy8, s_ready8);
            errors++;
        end
        stream_frame();
        vectors++;
        if (crc8 !== 8'hF4 || crc32 !== 32'hCBF43926) begin
            $display("FAIL reset_next: crc8=%h crc32=%h, want f4/cbf43926", crc8, crc32);
            errors++;
        end
        handshake();
    endtask

    task automatic test_single_byte();
        s_valid = 1'b0; s_last = 1'b1; s_data = 8'h55;
        tick(); tick();
        s_last = 1'b0;
        vectors++;
        if (crc_valid8 !== 1'b0 || busy8 !== 1'b0 || cnt8 !== 16'd9) begin
            $display("FAIL ignore_invalid: valid=%b busy=%b cnt=%0d, want 0/0/9", crc_valid8, busy8, cnt8);
            errors++;
        end
        s_valid = 1'b1; s_data = 8'h31; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        vectors++;
        if (crc_valid8 !== 1'b1 || crc8 !== 8'h97 || cnt8 !== 16'd1 || busy8 !== 1'b0) begin
            $display("FAIL single_byte: valid=%b crc=%h cnt=%0d busy=%b, want 1/97/1/0", crc_valid8, crc8, cnt8, busy8);
            errors++;
        end
        handshake();
    endtask

    initial begin
        msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34; msg[4] = 8'h35;
        msg[5] = 8'h36; msg[6] = 8'h37; msg[7] = 8'h38; msg[8] = 8'h39;
        test_reset();
        test_crc8();
        test_crc16();
        test_crc32();
        test_stall();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_single_byte();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
